// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the NTT datapath blocks.
//
// Contents:
//   Q         - Kyber modulus (3329)
//   DW        - coefficient width in bits
//   MM_LAT    - plantard_mm latency, A_in -> C_out, in clocks
//   NUM_PAIRS - butterflies per NTT layer
//   CNT_W     - width of the per-layer pair counter
//   coeff_t   - one coefficient, DW bits
package kyber_pkg;

  localparam int Q         = 3329;
  localparam int DW        = 12;
  localparam int MM_LAT    = 4;
  localparam int NUM_PAIRS = 128;
  localparam int CNT_W     = $clog2(NUM_PAIRS);

  typedef logic [DW-1:0] coeff_t;

endpackage

// File: rtl/mod_addsub.sv
// Modular add/subtract core of the Cooley-Tukey butterfly (combinational).
// Produces (a + t) mod Q and (a - t) mod Q for a, t < Q.
//
// Optional feature macro: NTT_BFLY_HALVE_EN
//   When defined, both results are additionally halved mod Q
//   (Gentleman-Sande / inverse-NTT scaling). When undefined, no halving
//   logic exists.
//
// Ports:
//   a    in  DW  upper coefficient, < Q
//   t    in  DW  twiddle product, < Q
//   sum  out DW  (a + t) mod Q  (optionally halved)
//   diff out DW  (a - t) mod Q  (optionally halved)
module mod_addsub
  import kyber_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] t,
  output logic [DW-1:0] sum,
  output logic [DW-1:0] diff
);

  localparam logic [DW:0] QW = (DW+1)'(Q);

  logic [DW:0] w_s;
  logic [DW:0] w_d;
  logic [DW:0] w_sumRaw;
  logic [DW:0] w_diffRaw;
  logic [DW:0] w_sumFin;
  logic [DW:0] w_diffFin;
  logic        w_unused;

  // One conditional correction is enough because both operands are < Q.
  // For the difference, the top bit of the 13-bit two's-complement result
  // is the borrow, i.e. a < t.
  assign w_s       = {1'b0, a} + {1'b0, t};
  assign w_d       = {1'b0, a} - {1'b0, t};
  assign w_sumRaw  = (w_s >= QW) ? (w_s - QW) : w_s;
  assign w_diffRaw = w_d[DW] ? (w_d + QW) : w_d;

`ifdef NTT_BFLY_HALVE_EN
  // Division by 2 mod Q: an odd value gets Q added first so the shift is
  // exact. x + Q < 2Q fits in DW+1 bits.
  function automatic logic [DW:0] half(input logic [DW:0] x);
    logic [DW:0] w_plusQ;
    w_plusQ = x + QW;
    return x[0] ? (w_plusQ >> 1) : (x >> 1);
  endfunction

  assign w_sumFin  = half(w_sumRaw);
  assign w_diffFin = half(w_diffRaw);
`else
  assign w_sumFin  = w_sumRaw;
  assign w_diffFin = w_diffRaw;
`endif

  // Results are always < Q, so the top bit is zero and is dropped.
  assign sum      = w_sumFin[DW-1:0];
  assign diff     = w_diffFin[DW-1:0];
  assign w_unused = &{1'b0, w_sumFin[DW], w_diffFin[DW]};

endmodule

// File: rtl/ntt_bfly_stage.sv
// Cooley-Tukey butterfly stage sitting downstream of plantard_mm.
// b_in is forwarded combinationally to the multiplier; a_in and in_valid
// travel through an MM_LAT-deep delay line so they meet the product
// t = b*w*R^-1 mod Q on mm_c_in. The stage registers (a+t) mod Q and
// (a-t) mod Q, counts output pairs and pulses layer_done at the end of
// each NTT layer.
//
// Optional feature macro: NTT_BFLY_HALVE_EN (halving inside mod_addsub).
//
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   synchronous reset, active-high
//   in_valid   in  1   a_in/b_in valid this cycle (no backpressure)
//   a_in       in  DW  upper coefficient, < Q
//   b_in       in  DW  lower coefficient, < Q (drive 0 when idle)
//   mm_a_out   out DW  to plantard_mm A_in, equals b_in
//   mm_c_in    in  DW  from plantard_mm C_out, < Q
//   out_valid  out 1   sum_out/diff_out valid
//   sum_out    out DW  (a + t) mod Q
//   diff_out   out DW  (a - t) mod Q
//   layer_done out 1   pulse with the NUM_PAIRS-th out_valid of a layer
//   busy       out 1   any valid pair in the delay line or output register
module ntt_bfly_stage
  import kyber_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] mm_a_out,
  input  logic [DW-1:0] mm_c_in,
  output logic          out_valid,
  output logic [DW-1:0] sum_out,
  output logic [DW-1:0] diff_out,
  output logic          layer_done,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAIRS - 1);

  // Index k-1 holds the inputs from k cycles ago; the top index is the tap
  // that lines up with the multiplier output.
  logic [MM_LAT-1:0][DW-1:0] r_aDly;
  logic [MM_LAT-1:0]         r_vDly;
  logic                      r_outValid;
  logic [DW-1:0]             r_sum;
  logic [DW-1:0]             r_diff;
  logic                      r_layerDone;
  logic [CNT_W-1:0]          r_cnt;

  logic [DW-1:0]             w_tapA;
  logic                      w_tapV;
  logic [DW-1:0]             w_sum;
  logic [DW-1:0]             w_diff;

  // plantard_mm carries no valid, so b goes straight through unregistered.
  assign mm_a_out = b_in;

  assign w_tapA = r_aDly[MM_LAT-1];
  assign w_tapV = r_vDly[MM_LAT-1];

  mod_addsub u_addsub (
    .a    (w_tapA),
    .t    (mm_c_in),
    .sum  (w_sum),
    .diff (w_diff)
  );

  // Delay line, output register and per-layer pair counter. A reset wipes
  // every in-flight valid bit, so pairs accepted before it never emerge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aDly      <= '0;
      r_vDly      <= '0;
      r_outValid  <= 1'b0;
      r_sum       <= '0;
      r_diff      <= '0;
      r_layerDone <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_aDly      <= {r_aDly[MM_LAT-2:0], a_in};
      r_vDly      <= {r_vDly[MM_LAT-2:0], in_valid};
      r_outValid  <= w_tapV;
      r_layerDone <= 1'b0;
      if (w_tapV) begin
        r_sum       <= w_sum;
        r_diff      <= w_diff;
        r_layerDone <= (r_cnt == LAST_CNT);
        r_cnt       <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_outValid;
  assign sum_out    = r_sum;
  assign diff_out   = r_diff;
  assign layer_done = r_layerDone;
  assign busy       = (|r_vDly) | r_outValid;

endmodule
